// File: rtl/led_arb_pkg.sv
// Shared definitions for the LED grant arbiter: channel count, select
// width and the arbiter state encoding.
package led_arb_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

endpackage : led_arb_pkg

// File: rtl/rr_pick.sv
// Round-robin picker: scans the request vector starting just after the
// last released owner and wrapping 3 -> 0. The first set bit wins. Purely
// combinational, so all 64 req/last combinations can be checked alone.
module rr_pick
    import led_arb_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] win,
    output logic             any
);

    // Walk the channels in priority order; the first requester found is kept.
    always_comb begin
        logic [SEL_W-1:0] idx;
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = last + SEL_W'(i + 1);
            if (!any && req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/led_grant_arbiter.sv
// Round-robin arbiter sharing the LED decoder between four button
// requesters. Each winner holds the LED for at least HOLD_CYCLES cycles and
// every hand-over passes through one dead GAP cycle. All outputs are flops.
module led_grant_arbiter
    import led_arb_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req,
    output logic [SEL_W-1:0] sel,
    output logic [N_CH-1:0]  gnt,
    output logic             busy
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_CH-1:0]  gnt_q, gnt_d;
    logic             busy_q, busy_d;

    logic [SEL_W-1:0] win;
    logic             any;

    rr_pick u_pick (
        .req  (req),
        .last (last_q),
        .win  (win),
        .any  (any)
    );

    // Next-state logic: arbitrate when idle or in the gap, otherwise count
    // the hold time and release once it has expired and someone wants out.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE, GAP: begin
                if (any) begin
                    gnt_d   = N_CH'(1) << win;
                    sel_d   = win;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = GRANT;
                end else begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!req[sel_q] || ((req & ~gnt_q) != '0)) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    last_d  = sel_q;
                    state_d = GAP;
                end
            end
            default: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; last=3 makes the
    // first scan after reset start at channel 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 2'b11;
            cnt_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    assign sel  = sel_q;
    assign gnt  = gnt_q;
    assign busy = busy_q;

endmodule : led_grant_arbiter

// File: tb/tb_led_grant_arbiter.sv
// Self-checking bench for led_grant_arbiter with HOLD_CYCLES=4. A
// behavioural model tracks the owner, how long it has held the LED and who
// was released last; outputs are compared on the falling edge.
module tb_led_grant_arbiter;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Reference model: owner = -1 when nobody holds the LED.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 3;
    int m_sel   = 0;

    led_grant_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .sel   (sel),
        .gnt   (gnt),
        .busy  (busy)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the model by one rising edge using the sampled inputs.
    task automatic modelStep(input logic [3:0] r, input logic rn);
        int w;
        bit others;
        if (!rn) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 3;
            m_sel   = 0;
        end else if (m_owner >= 0) begin
            if (m_held >= HOLD) begin
                others = 1'b0;
                for (int c = 0; c < 4; c++)
                    if (c != m_owner && r[c]) others = 1'b1;
                if (!r[m_owner] || others) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_held  = 0;
                end
            end else begin
                m_held++;
            end
        end else begin
            w = -1;
            for (int k = 1; k <= 4; k++)
                if (w < 0 && r[(m_last + k) % 4]) w = (m_last + k) % 4;
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
                m_sel   = w;
            end
        end
    endtask

    // Compare the DUT outputs against the model.
    task automatic checkOutput(input string tag);
        logic [3:0] exp_gnt;
        logic       exp_busy;
        exp_gnt  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        exp_busy = (m_owner >= 0);
        checks++;
        assert (gnt === exp_gnt) else begin
            errors++;
            $error("[TB] FAIL %s gnt: observed=%b expected=%b", tag, gnt, exp_gnt);
        end
        checks++;
        assert (busy === exp_busy) else begin
            errors++;
            $error("[TB] FAIL %s busy: observed=%b expected=%b", tag, busy, exp_busy);
        end
        checks++;
        assert (sel === 2'(m_sel)) else begin
            errors++;
            $error("[TB] FAIL %s sel: observed=%0d expected=%0d", tag, sel, m_sel);
        end
    endtask

    // Drive inputs, let one rising edge pass, step the model, check at negedge.
    task automatic applyStimulus(input logic [3:0] r, input logic rn, input string tag);
        req   = r;
        rst_n = rn;
        @(posedge clk);
        modelStep(r, rn);
        @(negedge clk);
        checkOutput(tag);
    endtask

    initial begin
        logic [3:0] rnd_req;
        req   = 4'b1111;
        rst_n = 1'b0;
        @(negedge clk);

        $display("[TB] reset with all requests pending");
        repeat (2) applyStimulus(4'b1111, 1'b0, "reset");

        $display("[TB] saturated load rotation");
        repeat (24) applyStimulus(4'b1111, 1'b1, "saturate");

        $display("[TB] single-cycle request on channel 2");
        applyStimulus(4'b0000, 1'b0, "reset2");
        applyStimulus(4'b0100, 1'b1, "pulse");
        repeat (8) applyStimulus(4'b0000, 1'b1, "pulse_hold");

        $display("[TB] long hold then contention");
        repeat (20) applyStimulus(4'b0001, 1'b1, "long_hold");
        repeat (8) applyStimulus(4'b1001, 1'b1, "contend");

        $display("[TB] wrap after channel 3 release");
        repeat (8) applyStimulus(4'b0011, 1'b1, "wrap");

        $display("[TB] reset during a channel 2 grant");
        applyStimulus(4'b0000, 1'b0, "reset3");
        repeat (3) applyStimulus(4'b0100, 1'b1, "pre_reset");
        applyStimulus(4'b0110, 1'b0, "mid_reset");
        repeat (6) applyStimulus(4'b0110, 1'b1, "post_reset");

        $display("[TB] randomized traffic");
        rnd_req = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) rnd_req = 4'($urandom_range(0, 15));
            applyStimulus(rnd_req, ($urandom_range(0, 63) != 0), "random");
            checks++;
            assert ((gnt & (gnt - 4'd1)) == 4'd0 && ((gnt != 4'd0) == busy)) else begin
                errors++;
                $error("[TB] FAIL onehot gnt=%b busy=%b required one-hot gnt matching busy", gnt, busy);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_led_grant_arbiter
